// File: rtl/icache_dm_burst.sv
// icache_dm_burst
//   Direct-mapped instruction cache with multi-word lines. Hits return the
//   instruction combinationally with no stall. A miss refills the whole line
//   one beat at a time over a valid/ready-style memory port. Supports global
//   invalidate and abandoning a refill on a branch mispredict.
//
// Parameters:
//   DATA_W         word width (32)
//   INDEX_W        index bits, 2**INDEX_W lines
//   WORDS_PER_LINE words per line, power of two 1..16
//   TAG_W          tag bits stored per line
//
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   addr           fetch byte address
//   predict_fail   fetch redirect, current addr is stale
//   invalidate     clear all valid bits
//   inst           instruction for addr (0 unless hit)
//   icache_stall   fetch must hold addr
//   mem_req        beat request valid
//   mem_addr       word-aligned beat address
//   mem_valid      mem_data valid for the outstanding beat
//   mem_data       returned word
//   hit_cnt        hit counter      (only with ICACHE_PERF_CNT_EN)
//   miss_cnt       miss counter     (only with ICACHE_PERF_CNT_EN)
//
// Optional build macro: ICACHE_PERF_CNT_EN adds the hit/miss counters.

module icache_dm_burst #(
    parameter int DATA_W         = 32,
    parameter int INDEX_W        = 8,
    parameter int WORDS_PER_LINE = 4,
    parameter int TAG_W          = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       addr,
    input  logic              predict_fail,
    input  logic              invalidate,
    output logic [DATA_W-1:0] inst,
    output logic              icache_stall,
    output logic              mem_req,
    output logic [31:0]       mem_addr,
    input  logic              mem_valid,
    input  logic [DATA_W-1:0] mem_data
`ifdef ICACHE_PERF_CNT_EN
    ,
    output logic [31:0]       hit_cnt,
    output logic [31:0]       miss_cnt
`endif
);

    localparam int OFF_W  = $clog2(WORDS_PER_LINE);
    // Word-select and beat-counter width; at least one bit so OFF_W = 0 works.
    localparam int SEL_W  = (OFF_W == 0) ? 1 : OFF_W;
    localparam int LINES  = 1 << INDEX_W;
    localparam int TOP    = 2 + OFF_W + INDEX_W + TAG_W;
    localparam int LINE_W = WORDS_PER_LINE * DATA_W;
    // Keeps tag and index bits, clears word offset and byte bits. When TOP is
    // 32 the shift wraps to 0 and the subtraction yields all ones, as wanted.
    localparam logic [31:0] LINE_MASK =
        ((32'd1 << TOP) - 32'd1) & ~((32'd1 << (2 + OFF_W)) - 32'd1);

    typedef enum logic [1:0] {IDLE, REFILL, DRAIN} state_t;

    state_t              state;
    logic [LINES-1:0]    valid;
    logic [TAG_W-1:0]    tag_store  [LINES];
    logic [LINE_W-1:0]   data_store [LINES];
    logic [LINE_W-1:0]   fill_buf;
    logic [LINE_W-1:0]   commit_line;
    logic [SEL_W-1:0]    cnt;
    logic [INDEX_W-1:0]  fill_index;
    logic [TAG_W-1:0]    fill_tag;
    logic                inv_seen;

    logic [SEL_W-1:0]    word_off;
    logic [INDEX_W-1:0]  index;
    logic [TAG_W-1:0]    tag;
    logic                hit;
    logic                start_fill;
    logic                beat_ok;
    logic                last_beat;
    logic                commit;

    assign word_off = SEL_W'((addr >> 2) & 32'(WORDS_PER_LINE - 1));
    assign index    = addr[2+OFF_W +: INDEX_W];
    assign tag      = addr[2+OFF_W+INDEX_W +: TAG_W];

    // Gating with rst keeps inst at 0 while reset is held, before valid is known.
    assign hit = !rst && (state == IDLE) && valid[index] && (tag_store[index] == tag);

    assign inst         = hit ? data_store[index][word_off*DATA_W +: DATA_W] : '0;
    assign icache_stall = !hit && !predict_fail;

    assign start_fill = (state == IDLE) && !hit && !predict_fail;
    assign beat_ok    = (state == REFILL) && mem_valid && !predict_fail;
    assign last_beat  = (cnt == SEL_W'(WORDS_PER_LINE - 1));
    assign commit     = beat_ok && last_beat;

    // The final word is written straight from mem_data in the commit cycle.
    always_comb begin
        commit_line = fill_buf;
        commit_line[(WORDS_PER_LINE-1)*DATA_W +: DATA_W] = mem_data;
    end

    // Control FSM: valid bits, beat counter and the registered memory request.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            valid      <= '0;
            cnt        <= '0;
            mem_req    <= 1'b0;
            mem_addr   <= '0;
            inv_seen   <= 1'b0;
            fill_index <= '0;
            fill_tag   <= '0;
        end else begin
            if (invalidate) begin
                valid <= '0;
            end
            case (state)
                IDLE: begin
                    if (start_fill) begin
                        fill_index <= index;
                        fill_tag   <= tag;
                        cnt        <= '0;
                        inv_seen   <= 1'b0;
                        mem_req    <= 1'b1;
                        mem_addr   <= addr & LINE_MASK;
                        state      <= REFILL;
                    end
                end
                REFILL: begin
                    if (invalidate) begin
                        inv_seen <= 1'b1;
                    end
                    if (predict_fail) begin
                        // A beat returning with the redirect ends the refill at once.
                        if (mem_valid) begin
                            mem_req <= 1'b0;
                            state   <= IDLE;
                        end else begin
                            state <= DRAIN;
                        end
                    end else if (mem_valid) begin
                        cnt <= cnt + SEL_W'(1);
                        if (last_beat) begin
                            // Overrides the global clear above only for this line;
                            // any invalidate since the refill began leaves it invalid.
                            valid[fill_index] <= !inv_seen && !invalidate;
                            mem_req           <= 1'b0;
                            state             <= IDLE;
                        end else begin
                            mem_addr <= mem_addr + 32'd4;
                        end
                    end
                end
                DRAIN: begin
                    if (mem_valid) begin
                        mem_req <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Fill buffer and line storage; contents are qualified by valid, so no reset.
    always_ff @(posedge clk) begin
        if (beat_ok) begin
            fill_buf[cnt*DATA_W +: DATA_W] <= mem_data;
        end
        if (commit) begin
            tag_store[fill_index]  <= fill_tag;
            data_store[fill_index] <= commit_line;
        end
    end

`ifdef ICACHE_PERF_CNT_EN
    // Performance counters, free-running and wrapping.
    always_ff @(posedge clk) begin
        if (rst) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else begin
            if (hit) begin
                hit_cnt <= hit_cnt + 32'd1;
            end
            if (start_fill) begin
                miss_cnt <= miss_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_icache_dm_burst.sv
// tb_icache_dm_burst
//   Self-checking bench for icache_dm_burst. A memory model answers beat
//   requests after a programmable latency with word = 0xA000_0000 | addr[23:0].
//   Expected beat addresses and fetch results are queued by the stimulus and
//   compared by a monitor whenever the DUT completes a beat or a fetch.
//   The DUT is built with TAG_W = 12 so that tag = addr[23:12] and address
//   bit 20 separates 0x0010_1000 from 0x0000_1000, while bit 24 is ignored.

module tb_icache_dm_burst;

    logic        clk;
    logic        rst;
    logic [31:0] addr;
    logic        predict_fail;
    logic        invalidate;
    logic [31:0] inst;
    logic        icache_stall;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_valid;
    logic [31:0] mem_data;
`ifdef ICACHE_PERF_CNT_EN
    logic [31:0] hit_cnt;
    logic [31:0] miss_cnt;
`endif

    typedef struct {
        logic [31:0] inst;
        int          stalls;
    } fetch_exp_t;

    fetch_exp_t  fetch_q[$];
    logic [31:0] beat_q[$];

    int checks     = 0;
    int errors     = 0;
    int mem_lat    = 2;
    int wait_cnt   = 0;
    int stall_cnt  = 0;
    bit fetch_en   = 0;
    bit fetch_done = 0;

    icache_dm_burst #(.TAG_W(12)) dut (
        .clk          (clk),
        .rst          (rst),
        .addr         (addr),
        .predict_fail (predict_fail),
        .invalidate   (invalidate),
        .inst         (inst),
        .icache_stall (icache_stall),
        .mem_req      (mem_req),
        .mem_addr     (mem_addr),
        .mem_valid    (mem_valid),
        .mem_data     (mem_data)
`ifdef ICACHE_PERF_CNT_EN
        ,
        .hit_cnt      (hit_cnt),
        .miss_cnt     (miss_cnt)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] memWord(input logic [31:0] a);
        return 32'hA000_0000 | (a & 32'h00FF_FFFF);
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [31:0] a, input logic pf, input logic inv);
        addr         = a;
        predict_fail = pf;
        invalidate   = inv;
    endtask

    task automatic pushLine(input logic [31:0] base);
        for (int i = 0; i < 4; i++) begin
            beat_q.push_back(base + 32'(4 * i));
        end
    endtask

    // Waits until at most n expected beats remain; returns at posedge+1.
    task automatic waitBeats(input int n, input string name);
        for (int i = 0; i < 200; i++) begin
            @(posedge clk);
            #1;
            if (beat_q.size() <= n) return;
        end
        checks++;
        errors++;
        $display("[TB] FAIL %s: timeout, %0d beats still pending, expected %0d", name,
                 beat_q.size(), n);
    endtask

    task automatic doFetch(input logic [31:0] a, input logic [31:0] exp_inst,
                           input int exp_stalls);
        fetch_exp_t e;
        e.inst   = exp_inst;
        e.stalls = exp_stalls;
        fetch_q.push_back(e);
        applyStimulus(a, 1'b0, 1'b0);
        fetch_done = 0;
        stall_cnt  = 0;
        fetch_en   = 1;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk);
            #1;
            if (fetch_done) break;
        end
        if (!fetch_done) begin
            checks++;
            errors++;
            $display("[TB] FAIL fetch_timeout: addr 0x%08h never completed, expected %0d stalls",
                     a, exp_stalls);
            fetch_q.delete();
        end
        fetch_en = 0;
    endtask

    // Memory model: counts cycles the current beat has been outstanding and
    // answers once the programmed latency has elapsed.
    always @(negedge clk) begin
        if (mem_req === 1'b1 && mem_valid !== 1'b1) wait_cnt++;
        else wait_cnt = 0;
    end

    always @(posedge clk) begin
        #1;
        mem_valid = (mem_req === 1'b1) && (wait_cnt >= mem_lat);
        mem_data  = mem_valid ? memWord(mem_addr) : 32'hDEAD_BEEF;
    end

    // Monitor: checks each accepted beat and each completed fetch.
    always @(negedge clk) begin
        fetch_exp_t me;
        logic [31:0] exp_beat;
        if (!rst) begin
            if (mem_req && mem_valid) begin
                if (beat_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_beat: got mem_addr 0x%08h, expected no beat",
                             mem_addr);
                end else begin
                    exp_beat = beat_q.pop_front();
                    checkOutput("mem_addr", mem_addr, exp_beat);
                end
            end
            if (fetch_en && !fetch_done) begin
                if (icache_stall) begin
                    stall_cnt++;
                end else if (fetch_q.size() != 0) begin
                    me = fetch_q.pop_front();
                    checkOutput("inst", inst, me.inst);
                    checkOutput("stall_cycles", 32'(stall_cnt), 32'(me.stalls));
                    checkOutput("req_on_hit", {31'b0, mem_req}, 32'd0);
                    fetch_done = 1;
                end
            end
        end
    end

    initial begin
        rst       = 1'b1;
        mem_valid = 1'b0;
        mem_data  = '0;
        applyStimulus(32'h0000_1008, 1'b0, 1'b0);

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_inst", inst, 32'h0);
        checkOutput("rst_mem_req", {31'b0, mem_req}, 32'd0);
        checkOutput("rst_stall", {31'b0, icache_stall}, 32'd1);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Cold miss, 2-cycle memory: 1 IDLE + 4 beats x 3 cycles of stall
        mem_lat = 2;
        pushLine(32'h0000_1000);
        doFetch(32'h0000_1008, 32'hA000_1008, 13);

        // Hits in the same line, plus an alias differing only in ignored bit 24
        doFetch(32'h0000_1000, 32'hA000_1000, 0);
        doFetch(32'h0000_1004, 32'hA000_1004, 0);
        doFetch(32'h0000_100C, 32'hA000_100C, 0);
        doFetch(32'h0100_1008, 32'hA000_1008, 0);

        // Same index, different tag evicts; zero-wait penalty is 5 cycles
        mem_lat = 0;
        pushLine(32'h0010_1000);
        doFetch(32'h0010_1004, 32'hA010_1004, 5);
        pushLine(32'h0000_1000);
        doFetch(32'h0000_1008, 32'hA000_1008, 5);

        // predict_fail while the 2nd beat is outstanding: drain it, no commit
        mem_lat = 2;
        beat_q.push_back(32'h0000_2040);
        beat_q.push_back(32'h0000_2044);
        applyStimulus(32'h0000_2048, 1'b0, 1'b0);
        waitBeats(1, "drain_first_beat");
        applyStimulus(32'h0000_1008, 1'b1, 1'b0);
        @(negedge clk);
        checkOutput("pf_stall", {31'b0, icache_stall}, 32'd0);
        checkOutput("pf_mem_req", {31'b0, mem_req}, 32'd1);
        @(posedge clk);
        #1;
        applyStimulus(32'h0000_1008, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("drain_mem_req", {31'b0, mem_req}, 32'd1);
        checkOutput("drain_mem_addr", mem_addr, 32'h0000_2044);
        checkOutput("drain_stall", {31'b0, icache_stall}, 32'd1);
        waitBeats(0, "drain_done");
        doFetch(32'h0000_1008, 32'hA000_1008, 0);
        mem_lat = 0;
        pushLine(32'h0000_2040);
        doFetch(32'h0000_2048, 32'hA000_2048, 5);

        // Global invalidate after fills: both lines miss again
        applyStimulus(32'h0000_2048, 1'b1, 1'b1);
        @(posedge clk);
        #1;
        pushLine(32'h0000_1000);
        doFetch(32'h0000_1008, 32'hA000_1008, 5);
        pushLine(32'h0000_2040);
        doFetch(32'h0000_2048, 32'hA000_2048, 5);

        // invalidate on the final-beat cycle: line stays invalid
        pushLine(32'h0000_3080);
        applyStimulus(32'h0000_3080, 1'b0, 1'b0);
        waitBeats(1, "inv_last_beat");
        applyStimulus(32'h0000_3080, 1'b0, 1'b1);
        @(posedge clk);
        #1;
        pushLine(32'h0000_3080);
        doFetch(32'h0000_3080, 32'hA000_3080, 5);

        // invalidate mid-refill: refill completes but is not validated
        pushLine(32'h0000_6010);
        applyStimulus(32'h0000_6010, 1'b0, 1'b0);
        waitBeats(3, "inv_mid_refill");
        applyStimulus(32'h0000_6010, 1'b0, 1'b1);
        @(posedge clk);
        #1;
        applyStimulus(32'h0000_6010, 1'b0, 1'b0);
        waitBeats(0, "inv_mid_done");
        pushLine(32'h0000_6010);
        doFetch(32'h0000_6010, 32'hA000_6010, 5);

        // Reset in the middle of a refill, before any beat returns
        mem_lat = 2;
        applyStimulus(32'h0000_5000, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        checkOutput("rst_mid_inst", inst, 32'h0);
        @(posedge clk);
        #1;
        @(negedge clk);
        checkOutput("rst_mid_mem_req", {31'b0, mem_req}, 32'd0);
`ifdef ICACHE_PERF_CNT_EN
        checkOutput("rst_hit_cnt", hit_cnt, 32'd0);
        checkOutput("rst_miss_cnt", miss_cnt, 32'd0);
`endif
        @(posedge clk);
        #1;
        rst     = 1'b0;
        mem_lat = 0;
        pushLine(32'h0000_1000);
        doFetch(32'h0000_1008, 32'hA000_1008, 5);
        doFetch(32'h0000_1000, 32'hA000_1000, 0);
        doFetch(32'h0000_1004, 32'hA000_1004, 0);
        applyStimulus(32'h0000_9000, 1'b1, 1'b0);
        @(negedge clk);
        checkOutput("pf_idle_mem_req", {31'b0, mem_req}, 32'd0);
`ifdef ICACHE_PERF_CNT_EN
        checkOutput("hit_cnt", hit_cnt, 32'd3);
        checkOutput("miss_cnt", miss_cnt, 32'd1);
`endif

        checkOutput("beats_left", 32'(beat_q.size()), 32'd0);
        checkOutput("fetches_left", 32'(fetch_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
